// File: rtl/mips_core_pkg.sv
// Shared refill-path types: FSM states, requester ids, latched request record and burst length clamp.
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = 5;
    localparam int ID_WIDTH   = 4;

    localparam logic REQ_ICACHE   = 1'b0;
    localparam logic REQ_PREFETCH = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } refill_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic                  id;
    } refill_req_t;

    // Zero or oversize beat counts become a full-length burst.
    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len,
                                                       input int max_burst);
        logic [LEN_WIDTH-1:0] max_len;
        max_len = LEN_WIDTH'(max_burst);
        if (len == '0 || len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/axi_read_if.sv
// AXI read address and read data channels of the shared refill port.
interface axi_read_address_if;
    logic [mips_core_pkg::ADDR_WIDTH-1:0] araddr;
    logic [mips_core_pkg::LEN_WIDTH-1:0]  arlen;
    logic                                 arvalid;
    logic [mips_core_pkg::ID_WIDTH-1:0]   arid;
    logic                                 arready;

    modport master (output araddr, arlen, arvalid, arid, input arready);
    modport slave  (input araddr, arlen, arvalid, arid, output arready);
endinterface

interface axi_read_data_if;
    logic [mips_core_pkg::DATA_WIDTH-1:0] rdata;
    logic                                 rvalid;
    logic                                 rready;

    modport master (input rdata, rvalid, output rready);
    modport slave  (output rdata, rvalid, input rready);
endinterface

// File: rtl/burst_beat_counter.sv
// Counts R beats of the current burst and flags the final one combinationally.
// Zero latency on last; no backpressure, advances on every accepted beat.
module burst_beat_counter
    import mips_core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 beat,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 last
);

    logic [LEN_WIDTH-1:0] count_q;

    assign last = (count_q == len - LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_q <= '0;
        end else if (beat) begin
            count_q <= last ? '0 : count_q + LEN_WIDTH'(1);
        end
    end

endmodule

// File: rtl/refill_arbiter.sv
// Arbitrates i-cache (req0) and prefetch (req1) refills onto one AXI read port, one burst at a time.
// Grant is same-cycle from IDLE; R beats pass through with zero latency; RREADY stays high so memory sets the pace.
module refill_arbiter
    import mips_core_pkg::*;
#(
    parameter int MAX_BURST    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_arvalid,
    input  logic [ADDR_WIDTH-1:0] req0_araddr,
    input  logic [LEN_WIDTH-1:0]  req0_arlen,
    output logic                  req0_arready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_rlast,

    input  logic                  req1_arvalid,
    input  logic [ADDR_WIDTH-1:0] req1_araddr,
    input  logic [LEN_WIDTH-1:0]  req1_arlen,
    output logic                  req1_arready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_rlast,

    input  logic                  flush,

    axi_read_address_if.master    mem_read_address,
    axi_read_data_if.master       mem_read_data
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    refill_state_t state_q, state_d;
    refill_req_t   lat_q, lat_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          drop_q, drop_d;
    logic          beat;
    logic          last_beat;
    logic          flush_req1;

    assign beat       = rst_n && (state_q == DATA) && mem_read_data.rvalid;
    assign flush_req1 = flush && (lat_q.id == REQ_PREFETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            starve_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        starve_d     = starve_q;
        drop_d       = drop_q;
        req0_arready = 1'b0;
        req1_arready = 1'b0;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (!req1_arvalid) begin
                    starve_d = '0;
                end
                // A flushed prefetch never competes, even when it is owed a grant.
                if (rst_n && req1_arvalid && !flush && (starve_q == STARVE_MAX || !req0_arvalid)) begin
                    req1_arready = 1'b1;
                    lat_d        = '{addr: req1_araddr, len: clamp_len(req1_arlen, MAX_BURST), id: REQ_PREFETCH};
                    starve_d     = '0;
                    state_d      = ADDR;
                end else if (rst_n && req0_arvalid) begin
                    req0_arready = 1'b1;
                    lat_d        = '{addr: req0_araddr, len: clamp_len(req0_arlen, MAX_BURST), id: REQ_ICACHE};
                    state_d      = ADDR;
                    if (req1_arvalid && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            ADDR: begin
                if (flush_req1) begin
                    drop_d = 1'b1;
                end
                if (mem_read_address.arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (flush_req1) begin
                    drop_d = 1'b1;
                end
                if (beat && last_beat) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    burst_beat_counter u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q != DATA),
        .beat  (beat),
        .len   (lat_q.len),
        .last  (last_beat)
    );

    assign mem_read_address.arvalid = rst_n && (state_q == ADDR);
    assign mem_read_address.araddr  = lat_q.addr;
    assign mem_read_address.arlen   = lat_q.len;
    assign mem_read_address.arid    = {{(ID_WIDTH-1){1'b0}}, lat_q.id};
    assign mem_read_data.rready     = 1'b1;

    // A dropped prefetch burst is still drained from memory, just not delivered.
    assign req0_rvalid = beat && (lat_q.id == REQ_ICACHE);
    assign req1_rvalid = beat && (lat_q.id == REQ_PREFETCH) && !drop_q;
    assign req0_rlast  = req0_rvalid && last_beat;
    assign req1_rlast  = req1_rvalid && last_beat;
    assign req0_rdata  = mem_read_data.rdata;
    assign req1_rdata  = mem_read_data.rdata;

endmodule

// File: doc/refill_arbiter.md
REFILL_ARBITER -- requirements
Module: refill_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16, SHALL set the maximum number of beats per burst.
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set how many consecutive req0 grants may pass while req1 waits before req1 is forced.
REQ-003 Port clk  in  1  SHALL be the clock.
REQ-004 Port rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 Ports req0_arvalid/req1_arvalid  in  1  SHALL carry the refill request (req0 = i-cache demand, req1 = stream-buffer prefetch).
REQ-006 Ports reqN_araddr  in  `ADDR_WIDTH  SHALL carry the line-aligned byte address.
REQ-007 Ports reqN_arlen  in  5  SHALL carry the beat count, 1..MAX_BURST.
REQ-008 Ports reqN_arready  out  1  SHALL be a one-cycle acceptance pulse.
REQ-009 Ports reqN_rvalid  out  1, reqN_rdata  out  `DATA_WIDTH, reqN_rlast  out  1  SHALL form the per-requester return beat.
REQ-010 Port flush  in  1  SHALL cancel prefetch traffic (PC redirect).
REQ-011 Ports mem_read_address.master / mem_read_data.master SHALL form the shared AXI read port (ARADDR, ARLEN, ARVALID, ARID, ARREADY; RDATA, RVALID, RREADY).

Function
REQ-012 The FSM SHALL have states IDLE, ADDR, DATA; one transaction SHALL be outstanding at a time.
REQ-013 In IDLE with any unmasked request, the block SHALL grant in that cycle, pulse the winner's reqN_arready, latch address, length and requester id, and enter ADDR.
REQ-014 Arbitration SHALL be fixed priority to req0, except that req1 SHALL win when starve_cnt == STARVE_LIMIT.
REQ-015 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each req0 grant while req1_arvalid is high, and SHALL clear on a req1 grant or when req1_arvalid is low in IDLE.
REQ-016 req1 SHALL be masked from arbitration in any cycle where flush is high.
REQ-017 In ADDR the block SHALL drive ARVALID=1, ARADDR/ARLEN from the latches and ARID = {3'b0, grant_id`, and SHALL hold them stable until ARREADY.
REQ-018 ARVALID SHALL never drop before ARREADY, even under flush; ADDR SHALL go to DATA on ARREADY.
REQ-019 RREADY SHALL be constantly 1.
REQ-020 In DATA, each RVALID beat SHALL be forwarded combinationally (0-cycle) to the granted requester's rvalid/rdata; the other requester's rvalid SHALL be 0.
REQ-021 A 5-bit beat counter SHALL count RVALID beats; reqN_rlast SHALL be 1 on the beat where count == latched arlen-1, and that beat SHALL return the FSM to IDLE.
REQ-022 Arbitration SHALL restart in the IDLE cycle that follows, so no grant happens on the last-beat cycle.
REQ-023 If flush is seen during ADDR or DATA of a req1 transaction, a sticky drop flag SHALL set; the burst SHALL be fully drained with req1_rvalid forced to 0 for the rest of it; the flag SHALL clear on return to IDLE.
REQ-024 Flush SHALL have no effect on req0 transactions.
REQ-025 reqN_arlen values of 0 or above MAX_BURST SHALL be clamped to MAX_BURST.
REQ-026 Simultaneous req0/req1 in IDLE SHALL resolve per REQ-014 within the same cycle.

Reset
REQ-027 On rst_n=0 at posedge clk: state=IDLE, starve_cnt=0, beat count=0, drop flag=0, grant_id=0.
REQ-028 During and after reset: all reqN_arready/rvalid/rlast=0 and ARVALID=0.
REQ-029 Reset mid-burst SHALL abandon the burst; the memory model is reset alongside.

Structure
REQ-030 The state enum and the requester-id constants (REQ_ICACHE=0, REQ_PREFETCH=1) SHALL live in mips_core_pkg.
REQ-031 The beat counter and rlast compare SHALL be a sub-module, burst_beat_counter.

Verification
REQ-032 Lone req0, addr 0x0000100, arlen 4, ARREADY after 2 cycles -> ARID=0, four req0_rvalid beats, rlast on beat 4, IDLE after it.
REQ-033 req0 and req1 asserted together -> req0 granted first; req1 granted in the IDLE cycle after req0's last beat.
REQ-034 req0 re-requests continuously while req1 is held -> after 4 req0 grants, the 5th grant goes to req1 (ARID=1).
REQ-035 flush during beat 2 of a 4-beat req1 burst -> beats 3-4 consumed with req1_rvalid=0; FSM reaches IDLE after 4 RVALIDs.
REQ-036 flush during ADDR with ARREADY delayed 3 cycles -> ARVALID held 3 cycles, ARADDR unchanged, burst drained silently.
REQ-037 rst_n low in DATA after beat 1 -> next cycle IDLE with all outputs 0; a fresh req0 is granted normally.
